// File: rtl/instr_memory_loadable_pkg.sv
// Shared definitions for the loadable instruction RAM.
// Contents: default widths and sizes, the core opcode set (so loaders and
// benches can build programs by name), and the load-controller state encoding.
// Ports: none (package).
package instr_memory_loadable_pkg;

  localparam int INSTR_W_DEF = 8;
  localparam int ADDR_W_DEF  = 8;
  localparam int DEPTH_DEF   = 256;
  localparam int N_CORES_DEF = 4;

  // Opcode 0 doubles as the value returned whenever no program is resident.
  localparam logic [7:0] OP_IDLE      = 8'd0;
  localparam logic [7:0] OP_LDAC      = 8'd4;
  localparam logic [7:0] OP_LDACM     = 8'd8;
  localparam logic [7:0] OP_STAC      = 8'd11;
  localparam logic [7:0] OP_CLAC      = 8'd19;
  localparam logic [7:0] OP_MOVR      = 8'd20;
  localparam logic [7:0] OP_MVACRT    = 8'd36;
  localparam logic [7:0] OP_ADD       = 8'd37;
  localparam logic [7:0] OP_MUL       = 8'd38;
  localparam logic [7:0] OP_SUB       = 8'd39;
  localparam logic [7:0] OP_INC       = 8'd40;
  localparam logic [7:0] OP_DEC       = 8'd41;
  localparam logic [7:0] OP_JPNZ      = 8'd42;
  localparam logic [7:0] OP_ENDOP     = 8'd46;
  localparam logic [7:0] OP_MOVRCOL1  = 8'd47;
  localparam logic [7:0] OP_MOVRCOL2  = 8'd48;
  localparam logic [7:0] OP_MVACRCOL1 = 8'd49;
  localparam logic [7:0] OP_MVACRCOL2 = 8'd50;
  localparam logic [7:0] OP_XOROP     = 8'd51;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_memory_loadable_load_ctrl.sv
// Program-load controller for the instruction RAM.
// Runs the IDLE/LOAD/DONE sequence, owns the write pointer, the valid/ready
// handshake, the sticky length-error flag and the "program resident" flag.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_start_i        request a load (only honoured in IDLE)
//   load_len_i          word count for the load, sampled with load_start_i
//   load_valid_i        a word is offered this cycle
//   load_ready_o        controller accepts a word this cycle
//   load_done_o         single-cycle pulse after the final word
//   load_err_o          sticky bad-length flag
//   prog_loaded_o       a complete program is resident
//   wr_en_o, wr_addr_o  RAM write strobe and address
module instr_load_ctrl
  import instr_memory_loadable_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic              prog_loaded_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;
  logic              loaded_q, loaded_d;
  logic              len_ok;
  logic              last_word;

  assign len_ok    = (load_len_i != '0) && (load_len_i <= DEPTH_L);
  assign last_word = ({1'b0, wr_ptr_q} == (len_q - (ADDR_W+1)'(1)));

  // State and bookkeeping registers; RAM contents live in the top level and
  // are deliberately untouched by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  // Next-state and handshake outputs. A rejected start only raises the error
  // flag, so the previously resident program stays readable.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    len_d        = len_q;
    err_d        = err_q;
    loaded_d     = loaded_q;
    load_ready_o = 1'b0;
    load_done_o  = 1'b0;
    wr_en_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          if (len_ok) begin
            state_d  = ST_LOAD;
            len_d    = load_len_i;
            wr_ptr_d = '0;
            err_d    = 1'b0;
            loaded_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          wr_en_o  = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (last_word) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        load_done_o = 1'b1;
        loaded_d    = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_err_o    = err_q;
  assign prog_loaded_o = loaded_q;
  assign wr_addr_o     = wr_ptr_q;

endmodule

// File: rtl/instr_memory_loadable.sv
// Run-time loadable instruction RAM shared by N_CORES cores.
// Programs stream in over a valid/ready interface; each core has its own
// registered (1-cycle latency) read port.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_start_i, load_len_i, load_valid_i, load_data_i   program load stream
//   load_ready_o, load_done_o, load_err_o, prog_loaded_o  load status
//   read_IRAM_i     per-core read enable
//   addr_i          per-core read address, core i in slice i
//   instr_out_o     per-core instruction, core i in slice i
module instr_memory_loadable
  import instr_memory_loadable_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int N_CORES = N_CORES_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_start_i,
  input  logic [ADDR_W:0]            load_len_i,
  input  logic                       load_valid_i,
  input  logic [INSTR_W-1:0]         load_data_i,
  output logic                       load_ready_o,
  output logic                       load_done_o,
  output logic                       load_err_o,
  output logic                       prog_loaded_o,
  input  logic [N_CORES-1:0]         read_IRAM_i,
  input  logic [N_CORES*ADDR_W-1:0]  addr_i,
  output logic [N_CORES*INSTR_W-1:0] instr_out_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [INSTR_W-1:0] ram_q [DEPTH];
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;

  instr_load_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_load_ctrl (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_start_i  (load_start_i),
    .load_len_i    (load_len_i),
    .load_valid_i  (load_valid_i),
    .load_ready_o  (load_ready_o),
    .load_done_o   (load_done_o),
    .load_err_o    (load_err_o),
    .prog_loaded_o (prog_loaded_o),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr)
  );

  // RAM write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) ram_q[wr_addr] <= load_data_i;
  end

  // One registered read port per core. Reads are blanked while no complete
  // program is resident, which also removes any read/write overlap during a load.
  for (genvar g = 0; g < N_CORES; g++) begin : g_rd
    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_q;

    assign rd_addr = addr_i[g*ADDR_W +: ADDR_W];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_q <= '0;
      end else if (read_IRAM_i[g]) begin
        if (prog_loaded_o && ({1'b0, rd_addr} < DEPTH_L)) rd_q <= ram_q[rd_addr];
        else                                              rd_q <= '0;
      end
    end

    assign instr_out_o[g*INSTR_W +: INSTR_W] = rd_q;
  end

endmodule

// File: tb/tb_instr_memory_loadable.sv
// Self-checking bench for instr_memory_loadable: drives program loads and
// multi-core reads, predicting results from a bench-side memory model.
module tb_instr_memory_loadable;

  logic        clk;
  logic        rst;
  logic        loadStart;
  logic [8:0]  loadLen;
  logic        loadValid;
  logic [7:0]  loadData;
  logic        loadReady;
  logic        loadDone;
  logic        loadErr;
  logic        progLoaded;
  logic [3:0]  readIram;
  logic [31:0] addr;
  logic [31:0] instrOut;

  instr_memory_loadable dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .load_start_i  (loadStart),
    .load_len_i    (loadLen),
    .load_valid_i  (loadValid),
    .load_data_i   (loadData),
    .load_ready_o  (loadReady),
    .load_done_o   (loadDone),
    .load_err_o    (loadErr),
    .prog_loaded_o (progLoaded),
    .read_IRAM_i   (readIram),
    .addr_i        (addr),
    .instr_out_o   (instrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         core;
    logic [7:0] exp;
  } sbEntry_t;

  sbEntry_t   sbQ[$];
  logic [7:0] benchMem [256];
  logic [7:0] prog [256];
  logic [7:0] modelOut [4];
  bit         modelLoaded;
  int         testCount;
  int         failCount;
  int         cycles;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    loadStart = 1'b0;
    loadValid = 1'b0;
    readIram = '0;
    tick();
    rst = 1'b0;
    modelLoaded = 1'b0;
    for (int i = 0; i < 4; i++) modelOut[i] = 8'd0;
  endtask

  // Drive one read cycle; expectations for all four cores go into the scoreboard
  // (disabled cores must hold their previous value).
  task automatic issueReads(input logic [3:0] en, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] a [4];
    sbEntry_t   e;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    readIram = en;
    for (int i = 0; i < 4; i++) begin
      addr[i*8 +: 8] = a[i];
      if (en[i]) modelOut[i] = modelLoaded ? benchMem[a[i]] : 8'd0;
      e.core = i;
      e.exp  = modelOut[i];
      sbQ.push_back(e);
    end
    tick();
    readIram = '0;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput($sformatf("rd_core%0d", e.core), 32'(instrOut[e.core*8 +: 8]), 32'(e.exp));
    end
  endtask

  task automatic startLoad(input int len);
    loadStart = 1'b1;
    loadLen = 9'(len);
    tick();
    loadStart = 1'b0;
    modelLoaded = 1'b0;
    checkOutput("start_ready", 32'(loadReady), 32'd1);
    checkOutput("start_err_clr", 32'(loadErr), 32'd0);
    checkOutput("start_loaded_clr", 32'(progLoaded), 32'd0);
  endtask

  // Feed words prog[0..count-1]; with toggle set, valid alternates 1,0,1,0 and
  // stall cycles carry junk data that must never land in the RAM.
  task automatic feedWords(input int count, input bit toggle, output int cyc);
    int idx;
    bit v;
    idx = 0;
    cyc = 0;
    while (idx < count && cyc < 2000) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      checkOutput("ready_in_load", 32'(loadReady), 32'd1);
      checkOutput("done_low_in_load", 32'(loadDone), 32'd0);
      loadValid = v;
      loadData = v ? prog[idx] : 8'hEE;
      @(posedge clk);
      cyc++;
      if (v) begin
        benchMem[idx] = prog[idx];
        idx++;
      end
      #1;
    end
    loadValid = 1'b0;
  endtask

  task automatic checkDone(input int expCycles);
    checkOutput("done_pulse", 32'(loadDone), 32'd1);
    checkOutput("done_latency", 32'(cycles), 32'(expCycles));
    checkOutput("done_ready_low", 32'(loadReady), 32'd0);
  endtask

  task automatic checkLoaded();
    checkOutput("loaded_set", 32'(progLoaded), 32'd1);
    checkOutput("done_cleared", 32'(loadDone), 32'd0);
    modelLoaded = 1'b1;
  endtask

  task automatic badStart(input int len);
    loadStart = 1'b1;
    loadLen = 9'(len);
    tick();
    loadStart = 1'b0;
    checkOutput($sformatf("err_len%0d", len), 32'(loadErr), 32'd1);
    checkOutput($sformatf("idle_len%0d", len), 32'(loadReady), 32'd0);
    checkOutput($sformatf("keep_loaded_len%0d", len), 32'(progLoaded), 32'd1);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b0;
    loadStart = 1'b0;
    loadLen = '0;
    loadValid = 1'b0;
    loadData = '0;
    readIram = '0;
    addr = '0;
    for (int i = 0; i < 256; i++) benchMem[i] = 8'd0;
    #2;
    doReset();

    // Reset state and blanked reads
    checkOutput("rst_loaded", 32'(progLoaded), 32'd0);
    checkOutput("rst_ready", 32'(loadReady), 32'd0);
    checkOutput("rst_done", 32'(loadDone), 32'd0);
    checkOutput("rst_err", 32'(loadErr), 32'd0);
    checkOutput("rst_out", instrOut, 32'd0);
    issueReads(4'hF, 8'd0, 8'd0, 8'd0, 8'd0);

    // Full-depth load so every address has known contents
    for (int i = 0; i < 256; i++) prog[i] = 8'((i * 7 + 3) % 256);
    startLoad(256);
    feedWords(256, 1'b0, cycles);
    checkDone(256);
    tick();
    checkLoaded();
    issueReads(4'hF, 8'd0, 8'd1, 8'd128, 8'd255);

    // XOR program, valid every cycle; a read issued in the DONE cycle still sees 0
    prog[0] = 8'd19; prog[1] = 8'd4;  prog[2] = 8'd4;   prog[3] = 8'd0;
    prog[4] = 8'd8;  prog[5] = 8'd20; prog[6] = 8'd4;   prog[7] = 8'd4;
    prog[8] = 8'd1;  prog[9] = 8'd8;  prog[10] = 8'd51; prog[11] = 8'd28;
    prog[12] = 8'd4; prog[13] = 8'd4; prog[14] = 8'd2;  prog[15] = 8'd11;
    prog[16] = 8'd46;
    startLoad(17);
    feedWords(17, 1'b0, cycles);
    checkDone(17);
    issueReads(4'h1, 8'd10, 8'd0, 8'd0, 8'd0);
    checkLoaded();
    issueReads(4'h1, 8'd10, 8'd0, 8'd0, 8'd0);
    checkOutput("xorop_at_10", 32'(instrOut[7:0]), 32'd51);

    // Four cores, shared and out-of-program addresses in one cycle
    issueReads(4'hF, 8'd0, 8'd16, 8'd16, 8'd255);
    checkOutput("core0_clac", 32'(instrOut[7:0]), 32'd19);
    checkOutput("core1_endop", 32'(instrOut[15:8]), 32'd46);
    issueReads(4'h2, 8'd0, 8'd5, 8'd0, 8'd0);

    // Stalled load: valid toggles, junk on stall cycles must be ignored
    for (int i = 0; i < 8; i++) prog[i] = 8'(8'hA0 + i);
    startLoad(8);
    feedWords(8, 1'b1, cycles);
    checkDone(15);
    tick();
    checkLoaded();
    for (int i = 0; i < 8; i += 4)
      issueReads(4'hF, 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3));
    issueReads(4'hF, 8'd8, 8'd9, 8'd16, 8'd200);

    // Bad lengths leave the old program readable; next good start clears the error
    badStart(0);
    issueReads(4'hF, 8'd3, 8'd7, 8'd8, 8'd255);
    badStart(257);
    issueReads(4'hF, 8'd0, 8'd6, 8'd10, 8'd100);
    for (int i = 0; i < 4; i++) prog[i] = 8'(8'h30 + i);
    startLoad(4);
    feedWords(4, 1'b0, cycles);
    checkDone(4);
    tick();
    checkLoaded();
    issueReads(4'hF, 8'd0, 8'd3, 8'd4, 8'd7);

    // Reset in the middle of a load, then a clean reload
    for (int i = 0; i < 10; i++) prog[i] = 8'(8'h50 + i);
    startLoad(10);
    feedWords(5, 1'b0, cycles);
    doReset();
    checkOutput("midrst_loaded", 32'(progLoaded), 32'd0);
    checkOutput("midrst_ready", 32'(loadReady), 32'd0);
    issueReads(4'hF, 8'd0, 8'd1, 8'd2, 8'd3);
    startLoad(10);
    feedWords(10, 1'b0, cycles);
    checkDone(10);
    tick();
    checkLoaded();
    issueReads(4'hF, 8'd0, 8'd4, 8'd9, 8'd10);
    issueReads(4'h8, 8'd0, 8'd0, 8'd0, 8'd5);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
